ex_stage: RTL and testbench

Execute stage of the 5-stage RV32IM pipeline, sitting between the ID/EX register and the memory stage.
- Selects forwarded operands and computes single-cycle ALU and multiply results.
- Runs signed/unsigned division and remainder on an iterative 32-cycle divider that stalls the front of the pipe.
- Registers results and control into the EX/MEM register that feeds the memory stage: address/result, store data, rd, memread, memwrite, memtoreg, regwrite.

---
 rtl/ex_stage.sv | 206 ++++++++++++++++++++
 tb/tb_ex_stage.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// RV32IM execute stage: operand forwarding, single-cycle ALU/multiplier,
// an iterative 32-step restoring divider, and the EX/MEM pipeline register.
module ex_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc_i,
   input  logic [31:0] rs1_data_i,
   input  logic [31:0] rs2_data_i,
   input  logic [31:0] imm_i,
   input  logic [4:0]  rd_i,
   input  logic [4:0]  alu_op_i,
   input  logic        alusrc_i,
   input  logic [1:0]  fwd_a_i,
   input  logic [1:0]  fwd_b_i,
   input  logic [31:0] wb_data_i,
   input  logic        memread_i,
   input  logic        memwrite_i,
   input  logic        memtoreg_i,
   input  logic        regwrite_i,
   input  logic        flush_i,
   output logic        stall_o,
   output logic [31:0] alu_rst_o,
   output logic [31:0] mem_wdata_o,
   output logic [4:0]  rd_o,
   output logic        memread_o,
   output logic        memwrite_o,
   output logic        memtoreg_o,
   output logic        regwrite_o
);

   localparam logic [4:0] OP_ADD    = 5'd0,  OP_SUB    = 5'd1,  OP_SLL  = 5'd2,
                          OP_SLT    = 5'd3,  OP_SLTU   = 5'd4,  OP_XOR  = 5'd5,
                          OP_SRL    = 5'd6,  OP_SRA    = 5'd7,  OP_OR   = 5'd8,
                          OP_AND    = 5'd9,  OP_LUI    = 5'd10, OP_AUIPC = 5'd11,
                          OP_LINK   = 5'd12, OP_MUL    = 5'd13, OP_MULH = 5'd14,
                          OP_MULHSU = 5'd15, OP_MULHU  = 5'd16, OP_DIV  = 5'd17,
                          OP_DIVU   = 5'd18, OP_REM    = 5'd19, OP_REMU = 5'd20;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t      state;
   logic [4:0]  cnt;

   logic [31:0]        op_a, fwd_b, op_b;
   logic signed [31:0] sa, sb;
   logic [31:0]        alu_res, ex_res;

   logic signed [32:0] mul_a, mul_b;
   logic signed [63:0] mul_a64, mul_b64, prod;

   logic        is_div, is_sdiv, div_zero, div_ovf, div_special, div_start;
   logic        a_neg, b_neg;
   logic [31:0] a_mag, b_mag, special_res;

   logic [31:0] div_q, div_r, div_d, div_res;
   logic [4:0]  div_op;
   logic        neg_q, neg_r;
   logic [32:0] r_sh, r_diff;

   function automatic logic [31:0] sign_fix(input logic [31:0] mag, input logic neg);
      return neg ? (~mag + 32'd1) : mag;
   endfunction

   always_comb begin
      case (fwd_a_i)
         2'b01:   op_a = alu_rst_o;
         2'b10:   op_a = wb_data_i;
         default: op_a = rs1_data_i;
      endcase
      case (fwd_b_i)
         2'b01:   fwd_b = alu_rst_o;
         2'b10:   fwd_b = wb_data_i;
         default: fwd_b = rs2_data_i;
      endcase
   end

   assign op_b = alusrc_i ? imm_i : fwd_b;
   assign sa   = op_a;
   assign sb   = op_b;

   // Sign-extend to 33 bits per operand signedness, then one signed multiply covers all four MUL forms.
   assign mul_a   = {((alu_op_i == OP_MULH) || (alu_op_i == OP_MULHSU)) & op_a[31], op_a};
   assign mul_b   = {(alu_op_i == OP_MULH) & op_b[31], op_b};
   assign mul_a64 = {{31{mul_a[32]}}, mul_a};
   assign mul_b64 = {{31{mul_b[32]}}, mul_b};
   assign prod    = mul_a64 * mul_b64;

   assign is_div      = (alu_op_i >= OP_DIV) && (alu_op_i <= OP_REMU);
   assign is_sdiv     = (alu_op_i == OP_DIV) || (alu_op_i == OP_REM);
   assign div_zero    = (op_b == 32'd0);
   assign div_ovf     = is_sdiv && (op_a == 32'h8000_0000) && (op_b == 32'hFFFF_FFFF);
   assign div_special = div_zero || div_ovf;
   assign a_neg       = is_sdiv && op_a[31];
   assign b_neg       = is_sdiv && op_b[31];
   assign a_mag       = a_neg ? (~op_a + 32'd1) : op_a;
   assign b_mag       = b_neg ? (~op_b + 32'd1) : op_b;

   always_comb begin
      special_res = 32'd0;
      if (div_zero)
         special_res = ((alu_op_i == OP_DIV) || (alu_op_i == OP_DIVU)) ? 32'hFFFF_FFFF : op_a;
      else if (alu_op_i == OP_DIV)
         special_res = 32'h8000_0000;
   end

   always_comb begin
      case (alu_op_i)
         OP_ADD:    alu_res = op_a + op_b;
         OP_SUB:    alu_res = op_a - op_b;
         OP_SLL:    alu_res = op_a << op_b[4:0];
         OP_SLT:    alu_res = {31'd0, sa < sb};
         OP_SLTU:   alu_res = {31'd0, op_a < op_b};
         OP_XOR:    alu_res = op_a ^ op_b;
         OP_SRL:    alu_res = op_a >> op_b[4:0];
         OP_SRA:    alu_res = sa >>> op_b[4:0];
         OP_OR:     alu_res = op_a | op_b;
         OP_AND:    alu_res = op_a & op_b;
         OP_LUI:    alu_res = op_b;
         OP_AUIPC:  alu_res = pc_i + op_b;
         OP_LINK:   alu_res = pc_i + 32'd4;
         OP_MUL:    alu_res = prod[31:0];
         OP_MULH, OP_MULHSU, OP_MULHU: alu_res = prod[63:32];
         OP_DIV, OP_DIVU, OP_REM, OP_REMU: alu_res = special_res;
         default:   alu_res = 32'd0;
      endcase
   end

   assign div_start = (state == IDLE) && is_div && !div_special && !flush_i;
   assign stall_o   = !rst && !flush_i && ((state == BUSY) || div_start);

   assign r_sh    = {div_r, div_q[31]};
   assign r_diff  = r_sh - {1'b0, div_d};
   assign div_res = ((div_op == OP_DIV) || (div_op == OP_DIVU)) ? sign_fix(div_q, neg_q)
                                                               : sign_fix(div_r, neg_r);
   assign ex_res  = (state == DONE) ? div_res : alu_res;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= 5'd0;
      end else if (flush_i) begin
         state <= IDLE;
         cnt   <= 5'd0;
      end else begin
         case (state)
            IDLE: if (div_start) begin
               state <= BUSY;
               cnt   <= 5'd0;
            end
            BUSY: begin
               cnt <= cnt + 5'd1;
               if (cnt == 5'd31) state <= DONE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Divider datapath: operands latched at issue, one restoring step per BUSY cycle.
   always_ff @(posedge clk) begin
      if (div_start) begin
         div_q  <= a_mag;
         div_r  <= 32'd0;
         div_d  <= b_mag;
         neg_q  <= a_neg ^ b_neg;
         neg_r  <= a_neg;
         div_op <= alu_op_i;
      end else if (state == BUSY) begin
         if (!r_diff[32]) begin
            div_r <= r_diff[31:0];
            div_q <= {div_q[30:0], 1'b1};
         end else begin
            div_r <= r_sh[31:0];
            div_q <= {div_q[30:0], 1'b0};
         end
      end
   end

   // EX/MEM register: bubbles keep data and clear rd and control.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         alu_rst_o   <= 32'd0;
         mem_wdata_o <= 32'd0;
         rd_o        <= 5'd0;
         memread_o   <= 1'b0;
         memwrite_o  <= 1'b0;
         memtoreg_o  <= 1'b0;
         regwrite_o  <= 1'b0;
      end else if (flush_i || stall_o) begin
         rd_o       <= 5'd0;
         memread_o  <= 1'b0;
         memwrite_o <= 1'b0;
         memtoreg_o <= 1'b0;
         regwrite_o <= 1'b0;
      end else begin
         alu_rst_o   <= ex_res;
         mem_wdata_o <= fwd_b;
         rd_o        <= rd_i;
         memread_o   <= memread_i;
         memwrite_o  <= memwrite_i;
         memtoreg_o  <= memtoreg_i;
         regwrite_o  <= regwrite_i;
      end
   end

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: ALU, forwarding, multiply, divider stall/result,
// division special cases, flush and asynchronous reset.
module tb_ex_stage;

   localparam logic [4:0] OP_ADD = 5'd0, OP_SUB = 5'd1, OP_SLL = 5'd2, OP_SLT = 5'd3,
                          OP_SLTU = 5'd4, OP_SRL = 5'd6, OP_SRA = 5'd7, OP_AUIPC = 5'd11,
                          OP_LINK = 5'd12, OP_MUL = 5'd13, OP_MULH = 5'd14, OP_MULHSU = 5'd15,
                          OP_MULHU = 5'd16, OP_DIV = 5'd17, OP_DIVU = 5'd18, OP_REM = 5'd19,
                          OP_REMU = 5'd20;

   logic        clk, rst;
   logic [31:0] pc_i, rs1_data_i, rs2_data_i, imm_i, wb_data_i;
   logic [4:0]  rd_i, alu_op_i;
   logic        alusrc_i, memread_i, memwrite_i, memtoreg_i, regwrite_i, flush_i;
   logic [1:0]  fwd_a_i, fwd_b_i;
   logic        stall_o;
   logic [31:0] alu_rst_o, mem_wdata_o;
   logic [4:0]  rd_o;
   logic        memread_o, memwrite_o, memtoreg_o, regwrite_o;

   int pass_cnt = 0;
   int total_cnt = 0;

   ex_stage dut (
      .clk(clk), .rst(rst), .pc_i(pc_i), .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
      .imm_i(imm_i), .rd_i(rd_i), .alu_op_i(alu_op_i), .alusrc_i(alusrc_i),
      .fwd_a_i(fwd_a_i), .fwd_b_i(fwd_b_i), .wb_data_i(wb_data_i),
      .memread_i(memread_i), .memwrite_i(memwrite_i), .memtoreg_i(memtoreg_i),
      .regwrite_i(regwrite_i), .flush_i(flush_i), .stall_o(stall_o),
      .alu_rst_o(alu_rst_o), .mem_wdata_o(mem_wdata_o), .rd_o(rd_o),
      .memread_o(memread_o), .memwrite_o(memwrite_o), .memtoreg_o(memtoreg_o),
      .regwrite_o(regwrite_o)
   );

   always #5 clk = ~clk;

   task automatic set_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] im, input logic src, input logic [4:0] rd);
      alu_op_i = op; rs1_data_i = a; rs2_data_i = b; imm_i = im; alusrc_i = src; rd_i = rd;
      fwd_a_i = 2'b00; fwd_b_i = 2'b00; wb_data_i = 32'd0; pc_i = 32'h100;
      memread_i = 1'b0; memwrite_i = 1'b0; memtoreg_i = 1'b0; regwrite_i = 1'b1; flush_i = 1'b0;
   endtask

   task automatic test_reset;
      repeat (2) @(posedge clk);
      #1;
      total_cnt++; if (alu_rst_o !== 32'd0) $display("FAIL reset_alu got %h expected 0", alu_rst_o); else pass_cnt++;
      total_cnt++; if (mem_wdata_o !== 32'd0) $display("FAIL reset_wdata got %h expected 0", mem_wdata_o); else pass_cnt++;
      total_cnt++; if (rd_o !== 5'd0) $display("FAIL reset_rd got %h expected 0", rd_o); else pass_cnt++;
      total_cnt++;
      if ({memread_o, memwrite_o, memtoreg_o, regwrite_o} !== 4'b0000)
         $display("FAIL reset_ctrl got %b expected 0000", {memread_o, memwrite_o, memtoreg_o, regwrite_o});
      else pass_cnt++;
      total_cnt++; if (stall_o !== 1'b0) $display("FAIL reset_stall got %b expected 0", stall_o); else pass_cnt++;
      rst = 1'b0;
   endtask

   task automatic test_add;
      set_op(OP_ADD, 32'd5, 32'd0, 32'hFFFF_FFFD, 1'b1, 5'd3);
      memtoreg_i = 1'b1;
      #1;
      total_cnt++; if (stall_o !== 1'b0) $display("FAIL add_stall got %b expected 0", stall_o); else pass_cnt++;
      @(posedge clk); #1;
      total_cnt++; if (alu_rst_o !== 32'd2) $display("FAIL add_result got %h expected 2", alu_rst_o); else pass_cnt++;
      total_cnt++; if (regwrite_o !== 1'b1) $display("FAIL add_regwrite got %b expected 1", regwrite_o); else pass_cnt++;
      total_cnt++; if (memtoreg_o !== 1'b1) $display("FAIL add_memtoreg got %b expected 1", memtoreg_o); else pass_cnt++;
      total_cnt++; if (rd_o !== 5'd3) $display("FAIL add_rd got %h expected 3", rd_o); else pass_cnt++;
   endtask

   task automatic test_forward;
      set_op(OP_ADD, 32'd10, 32'd20, 32'd0, 1'b0, 5'd4);
      @(posedge clk); #1;
      total_cnt++; if (alu_rst_o !== 32'd30) $display("FAIL fwd_base got %h expected 1e", alu_rst_o); else pass_cnt++;
      set_op(OP_SUB, 32'd999, 32'd5, 32'd0, 1'b0, 5'd4);
      fwd_a_i = 2'b01;
      @(posedge clk); #1;
      total_cnt++; if (alu_rst_o !== 32'd25) $display("FAIL fwd_a_exmem got %h expected 19", alu_rst_o); else pass_cnt++;
      set_op(OP_SUB, 32'd999, 32'd123, 32'd0, 1'b0, 5'd4);
      fwd_a_i = 2'b01; fwd_b_i = 2'b10; wb_data_i = 32'd7; memwrite_i = 1'b1;
      @(posedge clk); #1;
      total_cnt++; if (alu_rst_o !== 32'd18) $display("FAIL fwd_b_wb got %h expected 12", alu_rst_o); else pass_cnt++;
      total_cnt++; if (mem_wdata_o !== 32'd7) $display("FAIL fwd_wdata got %h expected 7", mem_wdata_o); else pass_cnt++;
      total_cnt++; if (memwrite_o !== 1'b1) $display("FAIL fwd_memwrite got %b expected 1", memwrite_o); else pass_cnt++;
   endtask

   task automatic test_alu;
      logic [4:0]  ops[10] = '{OP_SLL, OP_SRL, OP_SRA, OP_SLT, OP_SLTU, OP_AUIPC, OP_LINK, 5'd25,
                               OP_MUL, OP_MULH};
      logic [31:0] va[10]  = '{32'd1, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                               32'd0, 32'd0, 32'd55, 32'd7, 32'hFFFF_FFFF};
      logic [31:0] vb[10]  = '{32'd33, 32'd4, 32'd4, 32'd1, 32'd1, 32'h1000, 32'd0, 32'd66,
                               32'hFFFF_FFFD, 32'hFFFF_FFFF};
      logic [31:0] ve[10]  = '{32'd2, 32'h0800_0000, 32'hF800_0000, 32'd1, 32'd0, 32'h1100,
                               32'h104, 32'd0, 32'hFFFF_FFEB, 32'd0};
      for (int i = 0; i < 10; i++) begin
         set_op(ops[i], va[i], vb[i], 32'd0, 1'b0, 5'd9);
         @(posedge clk); #1;
         total_cnt++;
         if (alu_rst_o !== ve[i]) $display("FAIL alu_op%0d got %h expected %h", ops[i], alu_rst_o, ve[i]);
         else pass_cnt++;
      end
   endtask

   task automatic test_mul;
      logic [4:0]  ops[2] = '{OP_MULHU, OP_MULHSU};
      logic [31:0] ve[2]  = '{32'hFFFF_FFFE, 32'hFFFF_FFFF};
      for (int i = 0; i < 2; i++) begin
         set_op(ops[i], 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, 5'd10);
         #1;
         total_cnt++; if (stall_o !== 1'b0) $display("FAIL mul_stall_op%0d got %b expected 0", ops[i], stall_o); else pass_cnt++;
         @(posedge clk); #1;
         total_cnt++;
         if (alu_rst_o !== ve[i]) $display("FAIL mul_op%0d got %h expected %h", ops[i], alu_rst_o, ve[i]);
         else pass_cnt++;
      end
   endtask

   task automatic test_div;
      logic [4:0]  ops[3] = '{OP_DIV, OP_REM, OP_DIVU};
      logic [31:0] va[3]  = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100};
      logic [31:0] vb[3]  = '{32'd2, 32'd2, 32'd7};
      logic [31:0] ve[3]  = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14};
      int  n;
      logic bubble_ok;
      for (int i = 0; i < 3; i++) begin
         set_op(ops[i], va[i], vb[i], 32'd0, 1'b0, 5'd11);
         #1;
         n = 0; bubble_ok = 1'b1;
         while (stall_o === 1'b1 && n < 100) begin
            n++;
            @(posedge clk); #1;
            if (stall_o === 1'b1 && (regwrite_o !== 1'b0 || rd_o !== 5'd0)) bubble_ok = 1'b0;
         end
         total_cnt++; if (n != 33) $display("FAIL div_stall_len_op%0d got %0d expected 33", ops[i], n); else pass_cnt++;
         total_cnt++; if (!bubble_ok) $display("FAIL div_bubble_op%0d got 0 expected 1", ops[i]); else pass_cnt++;
         @(posedge clk); #1;
         total_cnt++;
         if (alu_rst_o !== ve[i]) $display("FAIL div_result_op%0d got %h expected %h", ops[i], alu_rst_o, ve[i]);
         else pass_cnt++;
         total_cnt++;
         if (regwrite_o !== 1'b1 || rd_o !== 5'd11)
            $display("FAIL div_ctrl_op%0d got %b/%h expected 1/0b", ops[i], regwrite_o, rd_o);
         else pass_cnt++;
      end
   endtask

   task automatic test_special;
      logic [4:0]  ops[5] = '{OP_DIVU, OP_REM, OP_DIV, OP_REM, OP_REMU};
      logic [31:0] va[5]  = '{32'd123, 32'd9, 32'h8000_0000, 32'h8000_0000, 32'd77};
      logic [31:0] vb[5]  = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0};
      logic [31:0] ve[5]  = '{32'hFFFF_FFFF, 32'd9, 32'h8000_0000, 32'd0, 32'd77};
      for (int i = 0; i < 5; i++) begin
         set_op(ops[i], va[i], vb[i], 32'd0, 1'b0, 5'd12);
         #1;
         total_cnt++; if (stall_o !== 1'b0) $display("FAIL special_stall_%0d got %b expected 0", i, stall_o); else pass_cnt++;
         @(posedge clk); #1;
         total_cnt++;
         if (alu_rst_o !== ve[i]) $display("FAIL special_result_%0d got %h expected %h", i, alu_rst_o, ve[i]);
         else pass_cnt++;
      end
   endtask

   task automatic test_flush;
      set_op(OP_ADD, 32'd1, 32'd1, 32'd0, 1'b0, 5'd13);
      @(posedge clk); #1;
      set_op(OP_ADD, 32'd1, 32'd1, 32'd0, 1'b0, 5'd13);
      flush_i = 1'b1;
      @(posedge clk); #1;
      total_cnt++;
      if (regwrite_o !== 1'b0 || rd_o !== 5'd0)
         $display("FAIL flush_idle_bubble got %b/%h expected 0/00", regwrite_o, rd_o);
      else pass_cnt++;
      set_op(OP_DIVU, 32'd100, 32'd7, 32'd0, 1'b0, 5'd6);
      @(posedge clk);
      repeat (9) @(posedge clk);
      #1;
      flush_i = 1'b1;
      #1;
      total_cnt++; if (stall_o !== 1'b0) $display("FAIL flush_stall got %b expected 0", stall_o); else pass_cnt++;
      @(posedge clk); #1;
      total_cnt++;
      if (regwrite_o !== 1'b0 || rd_o !== 5'd0)
         $display("FAIL flush_busy_bubble got %b/%h expected 0/00", regwrite_o, rd_o);
      else pass_cnt++;
      set_op(OP_ADD, 32'd1, 32'd2, 32'd0, 1'b0, 5'd7);
      #1;
      total_cnt++; if (stall_o !== 1'b0) $display("FAIL flush_idle_after got %b expected 0", stall_o); else pass_cnt++;
      @(posedge clk); #1;
      total_cnt++;
      if (alu_rst_o !== 32'd3 || regwrite_o !== 1'b1 || rd_o !== 5'd7)
         $display("FAIL flush_next_add got %h/%b/%h expected 3/1/07", alu_rst_o, regwrite_o, rd_o);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid_div;
      set_op(OP_ADD, 32'd4, 32'd9, 32'd0, 1'b0, 5'd8);
      @(posedge clk); #1;
      set_op(OP_DIV, 32'd100, 32'd7, 32'd0, 1'b0, 5'd8);
      repeat (6) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      total_cnt++;
      if (alu_rst_o !== 32'd0 || mem_wdata_o !== 32'd0 || rd_o !== 5'd0)
         $display("FAIL rst_mid_data got %h/%h/%h expected 0/0/0", alu_rst_o, mem_wdata_o, rd_o);
      else pass_cnt++;
      total_cnt++; if (stall_o !== 1'b0) $display("FAIL rst_mid_stall got %b expected 0", stall_o); else pass_cnt++;
      @(posedge clk); #1;
      set_op(OP_ADD, 32'd2, 32'd3, 32'd0, 1'b0, 5'd2);
      rst = 1'b0;
      #1;
      total_cnt++; if (stall_o !== 1'b0) $display("FAIL rst_mid_idle got %b expected 0", stall_o); else pass_cnt++;
      @(posedge clk); #1;
      total_cnt++; if (alu_rst_o !== 32'd5) $display("FAIL rst_mid_next_add got %h expected 5", alu_rst_o); else pass_cnt++;
   endtask

   initial begin
      clk = 1'b0;
      rst = 1'b1;
      set_op(OP_ADD, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0);
      regwrite_i = 1'b0;
      test_reset;
      test_add;
      test_forward;
      test_alu;
      test_mul;
      test_div;
      test_special;
      test_flush;
      test_reset_mid_div;
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
